// File: rtl/enemy_mover_if.sv
// Signal bundle between the enemy mover and its neighbours: the game control
// and spawn generator drive game_en/hit/randint, the mover returns its
// position and status to the renderer, collision logic and generator.
interface enemy_mover_if;
    logic        game_en;
    logic        hit;
    logic [9:0]  randint;
    logic [11:0] ENEMY_X;
    logic [11:0] ENEMY_Y;
    logic        enemy_active;
    logic        respawn_req;
    logic [7:0]  respawn_cnt;

    // Game side: drives control and spawn Y, observes the enemy.
    modport master (
        output game_en, hit, randint,
        input  ENEMY_X, ENEMY_Y, enemy_active, respawn_req, respawn_cnt
    );

    // Mover side: owns the enemy position and status.
    modport slave (
        input  game_en, hit, randint,
        output ENEMY_X, ENEMY_Y, enemy_active, respawn_req, respawn_cnt
    );
endinterface

// File: rtl/enemy_mover.sv
// enemy_mover: moves one enemy sprite leftwards at a fixed tick rate, and on
// reaching the left edge (or being hit) holds X at the edge for SETTLE cycles
// so the spawn generator can refresh randint, then latches the new Y and
// restarts at X_START.
// Optional build macro ENEMY_SPEEDUP_EN: step grows by 1 every 8 respawns,
// capped at STEP+4. Without it the step is the constant STEP.
module enemy_mover #(
    parameter logic [11:0] X_START  = 12'd1010,
    parameter logic [11:0] X_EDGE   = 12'd30,
    parameter logic [11:0] Y_INIT   = 12'd350,
    parameter logic [11:0] Y_MAX    = 12'd700,
    parameter int unsigned STEP     = 4,
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned SETTLE   = 2
) (
    input logic          clk,
    input logic          rst,
    enemy_mover_if.slave bus
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        RESPAWN
    } state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                move_tick;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [11:0]         x_q, x_nxt;
    logic [11:0]         y_q, y_nxt;
    logic [7:0]          cnt_q, cnt_nxt;
    logic [11:0]         step;
    logic [12:0]         edge_plus_step;
    logic [11:0]         x_moved;
    logic [11:0]         spawn_y;
    logic                spawn_ok;

    // Move-rate divider: free-runs while the game is enabled, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst || !bus.game_en) begin
            tick_cnt <= '0;
        end else if (move_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign move_tick = bus.game_en && (tick_cnt == TICK_LAST);

`ifdef ENEMY_SPEEDUP_EN
    logic [4:0] bonus_raw;
    assign bonus_raw = cnt_q[7:3];
    assign step      = 12'(STEP) + ((bonus_raw > 5'd4) ? 12'd4 : {7'd0, bonus_raw});
`else
    assign step = 12'(STEP);
`endif

    // Saturating left move: land exactly on X_EDGE rather than stepping past it.
    assign edge_plus_step = {1'b0, X_EDGE} + {1'b0, step};
    assign x_moved        = ({1'b0, x_q} > edge_plus_step) ? (x_q - step) : X_EDGE;

    // Zero or out-of-range spawn values leave the previous Y in place.
    assign spawn_y  = {2'b00, bus.randint};
    assign spawn_ok = (spawn_y != 12'd0) && (spawn_y <= Y_MAX);

    // Next-state and next-position decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        x_nxt      = x_q;
        y_nxt      = y_q;
        cnt_nxt    = cnt_q;
        settle_nxt = settle_cnt;
        unique case (state)
            IDLE: begin
                if (bus.game_en) begin
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (!bus.game_en) begin
                    state_nxt = IDLE;
                end else if (bus.hit) begin
                    // Pin X to the edge so the generator sees the same condition
                    // as a natural exit; a coincident tick is discarded.
                    state_nxt  = RESPAWN;
                    x_nxt      = X_EDGE;
                    settle_nxt = '0;
                end else if (x_q <= X_EDGE) begin
                    state_nxt  = RESPAWN;
                    settle_nxt = '0;
                end else if (move_tick) begin
                    x_nxt = x_moved;
                end
            end
            RESPAWN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    if (spawn_ok) begin
                        y_nxt = spawn_y;
                    end
                    x_nxt      = X_START;
                    cnt_nxt    = cnt_q + 8'd1;
                    settle_nxt = '0;
                    state_nxt  = bus.game_en ? MOVE : IDLE;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and position registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (rst) begin
            state      <= IDLE;
            x_q        <= X_START;
            y_q        <= Y_INIT;
            cnt_q      <= 8'd0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            cnt_q      <= cnt_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    assign bus.ENEMY_X      = x_q;
    assign bus.ENEMY_Y      = y_q;
    assign bus.enemy_active = (state == MOVE);
    assign bus.respawn_req  = (state == RESPAWN);
    assign bus.respawn_cnt  = cnt_q;

endmodule

// File: tb/tb_enemy_mover.sv
// Self-checking bench for enemy_mover. Two instances share all inputs: one
// with the standard X_START (1010) and one starting at 1012 so that X = 32
// and X = 600/800 are reachable with a step of 4. Both are compared every
// cycle against a behavioural model, plus directed boundary checks.
module tb_enemy_mover;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 4;
    localparam int SETTLE   = 2;
    localparam int X_START  = 1010;
    localparam int XB_START = 1012;
    localparam int X_EDGE   = 30;
    localparam int Y_INIT   = 350;
    localparam int Y_MAX    = 700;

`ifdef ENEMY_SPEEDUP_EN
    localparam int EXP_X_AFTER8  = 1005;
    localparam int EXP_X_AFTER40 = 1002;
`else
    localparam int EXP_X_AFTER8  = 1006;
    localparam int EXP_X_AFTER40 = 1006;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       game_en;
    logic       hit;
    logic [9:0] randint;

    int checks = 0;
    int errors = 0;

    enemy_mover_if bus_a ();
    enemy_mover_if bus_b ();

    assign bus_a.game_en = game_en;
    assign bus_a.hit     = hit;
    assign bus_a.randint = randint;
    assign bus_b.game_en = game_en;
    assign bus_b.hit     = hit;
    assign bus_b.randint = randint;

    enemy_mover #(
        .X_START (12'(X_START)),
        .STEP    (STEP),
        .TICK_DIV(TICK_DIV),
        .SETTLE  (SETTLE)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    enemy_mover #(
        .X_START (12'(XB_START)),
        .STEP    (STEP),
        .TICK_DIV(TICK_DIV),
        .SETTLE  (SETTLE)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: "run" = game running, resp_left = settle cycles still
    // to go before the new spawn (0 when not respawning), phase = divider count.
    typedef struct packed {
        int x;
        int y;
        int cnt;
        bit run;
        int resp_left;
        int phase;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset(int xs);
        mdl_t m;
        m.x         = xs;
        m.y         = Y_INIT;
        m.cnt       = 0;
        m.run       = 1'b0;
        m.resp_left = 0;
        m.phase     = 0;
        return m;
    endfunction

    function automatic int mdl_step(int cnt);
        int bonus;
        bonus = (cnt / 8 > 4) ? 4 : cnt / 8;
`ifndef ENEMY_SPEEDUP_EN
        bonus = 0;
`endif
        return STEP + bonus;
    endfunction

    function automatic mdl_t mdl_edge(mdl_t m, int xs, bit ge, bit h, int ri, bit r);
        mdl_t n;
        bit   tick;
        int   moved;
        if (r) return mdl_reset(xs);
        n       = m;
        tick    = ge && (m.phase == TICK_DIV - 1);
        n.phase = ge ? (m.phase + 1) % TICK_DIV : 0;
        if (m.resp_left > 0) begin
            if (m.resp_left == 1) begin
                if (ri != 0 && ri <= Y_MAX) n.y = ri;
                n.x         = xs;
                n.cnt       = (m.cnt + 1) % 256;
                n.run       = ge;
                n.resp_left = 0;
            end else begin
                n.resp_left = m.resp_left - 1;
            end
        end else if (!m.run) begin
            n.run = ge;
        end else if (!ge) begin
            n.run = 1'b0;
        end else if (h) begin
            n.x         = X_EDGE;
            n.resp_left = SETTLE;
        end else if (m.x <= X_EDGE) begin
            n.resp_left = SETTLE;
        end else if (tick) begin
            moved = m.x - mdl_step(m.cnt);
            n.x   = (moved < X_EDGE) ? X_EDGE : moved;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a.x",      bus_a.ENEMY_X,      ma.x);
        check("a.y",      bus_a.ENEMY_Y,      ma.y);
        check("a.active", bus_a.enemy_active, (ma.run && ma.resp_left == 0) ? 1 : 0);
        check("a.req",    bus_a.respawn_req,  (ma.resp_left > 0) ? 1 : 0);
        check("a.cnt",    bus_a.respawn_cnt,  ma.cnt);
        check("b.x",      bus_b.ENEMY_X,      mb.x);
        check("b.y",      bus_b.ENEMY_Y,      mb.y);
        check("b.active", bus_b.enemy_active, (mb.run && mb.resp_left == 0) ? 1 : 0);
        check("b.req",    bus_b.respawn_req,  (mb.resp_left > 0) ? 1 : 0);
        check("b.cnt",    bus_b.respawn_cnt,  mb.cnt);
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        ma = mdl_edge(ma, X_START,  game_en, hit, int'(randint), rst);
        mb = mdl_edge(mb, XB_START, game_en, hit, int'(randint), rst);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hit_respawn();
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        repeat (SETTLE) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ri_tab[4];
        int y_tab[4];
        ri_tab = '{0, 1000, 700, 701};
        y_tab  = '{250, 250, 700, 700};

        ma      = mdl_reset(X_START);
        mb      = mdl_reset(XB_START);
        rst     = 1'b1;
        game_en = 1'b1;
        hit     = 1'b0;
        randint = 10'd550;

        // Reset with game_en high.
        repeat (3) cycle();
        check("rst.x",      bus_a.ENEMY_X, 1010);
        check("rst.y",      bus_a.ENEMY_Y, 350);
        check("rst.active", bus_a.enemy_active, 0);
        check("rst.cnt",    bus_a.respawn_cnt, 0);

        rst = 1'b0;
        cycle();
        check("start.active", bus_a.enemy_active, 1);
        repeat (3) cycle();
        check("first.tick", bus_a.ENEMY_X, 1006);

        // Natural exit at the left edge: A arrives from 34, B saturates from 32.
        for (int i = 0; i < 2000 && ma.x != 34; i++) cycle();
        check("a.at34", bus_a.ENEMY_X, 34);
        for (int i = 0; i < TICK_DIV + 1 && ma.x == 34; i++) cycle();
        check("a.edge30", bus_a.ENEMY_X, X_EDGE);
        cycle();
        check("a.req_on", bus_a.respawn_req, 1);
        repeat (2) cycle();
        check("a.resp_x",   bus_a.ENEMY_X, 1010);
        check("a.resp_y",   bus_a.ENEMY_Y, 550);
        check("a.resp_cnt", bus_a.respawn_cnt, 1);
        check("b.at32", bus_b.ENEMY_X, 32);
        for (int i = 0; i < TICK_DIV + 1 && mb.x == 32; i++) cycle();
        check("b.sat30", bus_b.ENEMY_X, X_EDGE);
        cycle();
        check("b.req_on", bus_b.respawn_req, 1);
        repeat (2) cycle();
        check("b.resp_x",   bus_b.ENEMY_X, 1012);
        check("b.resp_y",   bus_b.ENEMY_Y, 550);
        check("b.resp_cnt", bus_b.respawn_cnt, 1);

        // Hit at X = 600, second hit during RESPAWN must be ignored.
        for (int i = 0; i < 2000 && mb.x != 600; i++) cycle();
        check("b.at600", bus_b.ENEMY_X, 600);
        randint = 10'd250;
        hit     = 1'b1;
        cycle();
        hit = 1'b0;
        check("hit.b_x", bus_b.ENEMY_X, X_EDGE);
        check("hit.a_x", bus_a.ENEMY_X, X_EDGE);
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        check("hit2.req", bus_b.respawn_req, 1);
        check("hit2.x",   bus_b.ENEMY_X, X_EDGE);
        cycle();
        check("hit.b_resp_x", bus_b.ENEMY_X, 1012);
        check("hit.b_resp_y", bus_b.ENEMY_Y, 250);
        check("hit.a_resp_x", bus_a.ENEMY_X, 1010);
        check("hit.a_resp_y", bus_a.ENEMY_Y, 250);
        check("hit.a_cnt",    bus_a.respawn_cnt, 2);

        // Spawn legality: 0 and >700 rejected, 700 accepted, 701 rejected.
        for (int i = 0; i < 4; i++) begin
            randint = 10'(ri_tab[i]);
            hit_respawn();
            check("spawn.y",   bus_a.ENEMY_Y, y_tab[i]);
            check("spawn.cnt", bus_a.respawn_cnt, 3 + i);
        end

        // Pause at X = 800 for 20 cycles, then resume after a full divider period.
        for (int i = 0; i < 2000 && mb.x != 800; i++) cycle();
        check("b.at800", bus_b.ENEMY_X, 800);
        game_en = 1'b0;
        repeat (20) cycle();
        check("pause.x",      bus_b.ENEMY_X, 800);
        check("pause.active", bus_b.enemy_active, 0);
        game_en = 1'b1;
        cycle();
        check("resume.active", bus_b.enemy_active, 1);
        repeat (2) cycle();
        check("resume.hold", bus_b.ENEMY_X, 800);
        cycle();
        check("resume.move", bus_b.ENEMY_X, 796);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int pick;
            rst     = ($urandom_range(0, 499) == 0);
            game_en = ($urandom_range(0, 15) != 0);
            hit     = ($urandom_range(0, 63) == 0);
            pick    = int'($urandom_range(0, 7));
            case (pick)
                0:       randint = 10'd0;
                1:       randint = 10'd700;
                2:       randint = 10'd701;
                3:       randint = 10'd1023;
                default: randint = 10'($urandom_range(1, 700));
            endcase
            cycle();
        end

        // Step growth with respawn count (constant step when the option is off).
        rst     = 1'b1;
        game_en = 1'b1;
        hit     = 1'b0;
        randint = 10'd100;
        cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) hit_respawn();
        check("speed.cnt8", bus_a.respawn_cnt, 8);
        for (int i = 0; i < TICK_DIV + 1 && ma.x == X_START; i++) cycle();
        check("speed.step8", bus_a.ENEMY_X, EXP_X_AFTER8);
        for (int i = 0; i < 32; i++) hit_respawn();
        check("speed.cnt40", bus_a.respawn_cnt, 40);
        for (int i = 0; i < TICK_DIV + 1 && ma.x == X_START; i++) cycle();
        check("speed.cap", bus_a.ENEMY_X, EXP_X_AFTER40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
